// File: rtl/fft_pkg.sv
// Shared definitions for the FFT I/O sequencer: state encoding and sample width.
package fft_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    LOAD    = 3'd0,
    FLUSH   = 3'd1,
    KICK    = 3'd2,
    COMPUTE = 3'd3,
    FETCH   = 3'd4,
    LATCH   = 3'd5,
    DRAIN0  = 3'd6,
    DRAIN1  = 3'd7
  } state_t;

  // A complex sample packs {re, im} side by side.
  function automatic int sample_width(input int word_size);
    return 2 * word_size;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit reversal of an address_width-bit RAM address.
module bit_reverse #(
  parameter int address_width = 5
) (
  input  logic [address_width-1:0] address,
  output logic [address_width-1:0] reversed
);

  for (genvar b = 0; b < address_width; b++) begin : g_rev
    assign reversed[b] = address[address_width-1-b];
  end

endmodule

// File: rtl/fft_io_controller.sv
// Frame I/O sequencer: loads N samples into the compute RAM in bit-reversed pairs,
// kicks the FFT core, then reads results back in natural order with backpressure.
module fft_io_controller
  import fft_pkg::*;
#(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [sample_width(word_size)-1:0]   in_sample,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sample_width(word_size)-1:0]   out_sample,
  output logic                                 out_last,
  output logic                                 fft_start,
  input  logic                                 fft_done,
  output logic                                 io_wr_en,
  output logic [address_width-1:0]             io_wr_address1,
  output logic [address_width-1:0]             io_wr_address2,
  output logic [sample_width(word_size)-1:0]   io_wr_sample1,
  output logic [sample_width(word_size)-1:0]   io_wr_sample2,
  output logic [address_width-1:0]             io_rd_address1,
  output logic [address_width-1:0]             io_rd_address2,
  input  logic [sample_width(word_size)-1:0]   io_rd_sample1,
  input  logic [sample_width(word_size)-1:0]   io_rd_sample2
);

  localparam int SW = sample_width(word_size);
  localparam logic [address_width-1:0] LAST_IN   = address_width'(N - 1);
  localparam logic [address_width-1:0] HALF      = address_width'(N / 2);
  localparam logic [address_width-2:0] LAST_PAIR = (address_width - 1)'(N / 2 - 1);

  state_t state, next_state;

  logic [address_width-1:0] in_count;
  logic [address_width-2:0] out_pair;
  logic [address_width-2:0] next_pair;
  logic [SW-1:0]            pair_reg;
  logic [SW-1:0]            buffer0;
  logic [SW-1:0]            buffer1;
  logic [address_width-1:0] even_address;
  logic [address_width-1:0] even_address_rev;
  logic                     accept;

  assign accept       = in_valid & in_ready;
  assign next_pair    = out_pair + (address_width - 1)'(1);
  assign even_address = {in_count[address_width-1:1], 1'b0};

  // The odd partner of a pair differs only in the LSB, which becomes the MSB once reversed.
  bit_reverse #(
    .address_width(address_width)
  ) u_bit_reverse (
    .address (even_address),
    .reversed(even_address_rev)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= next_state;
  end

  // in_ready is gated with reset so nothing is offered while the block is held in reset.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    fft_start  = 1'b0;
    out_sample = buffer0;
    unique case (state)
      LOAD: begin
        in_ready = reset;
        if (in_valid && in_count == LAST_IN) next_state = FLUSH;
      end
      FLUSH:   next_state = KICK;
      KICK: begin
        fft_start  = 1'b1;
        next_state = COMPUTE;
      end
      COMPUTE: if (fft_done) next_state = FETCH;
      FETCH:   next_state = LATCH;
      LATCH:   next_state = DRAIN0;
      DRAIN0: begin
        out_valid = 1'b1;
        if (out_ready) next_state = DRAIN1;
      end
      DRAIN1: begin
        out_valid  = 1'b1;
        out_sample = buffer1;
        out_last   = (out_pair == LAST_PAIR);
        if (out_ready) next_state = (out_pair == LAST_PAIR) ? LOAD : FETCH;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_count       <= '0;
      out_pair       <= '0;
      pair_reg       <= '0;
      buffer0        <= '0;
      buffer1        <= '0;
      io_wr_en       <= 1'b0;
      io_wr_address1 <= '0;
      io_wr_address2 <= '0;
      io_wr_sample1  <= '0;
      io_wr_sample2  <= '0;
      io_rd_address1 <= '0;
      io_rd_address2 <= '0;
    end else begin
      io_wr_en <= 1'b0;
      if (accept) begin
        in_count <= in_count + address_width'(1);
        if (!in_count[0]) begin
          pair_reg <= in_sample;
        end else begin
          io_wr_en       <= 1'b1;
          io_wr_address1 <= even_address_rev;
          io_wr_address2 <= even_address_rev + HALF;
          io_wr_sample1  <= pair_reg;
          io_wr_sample2  <= in_sample;
        end
      end
      // Read addresses are loaded on entry to FETCH and then held until the next FETCH.
      if (state == COMPUTE && fft_done) begin
        io_rd_address1 <= '0;
        io_rd_address2 <= address_width'(1);
      end
      if (state == LATCH) begin
        buffer0 <= io_rd_sample1;
        buffer1 <= io_rd_sample2;
      end
      if (state == DRAIN1 && out_ready) begin
        if (out_pair == LAST_PAIR) begin
          out_pair <= '0;
        end else begin
          out_pair       <= next_pair;
          io_rd_address1 <= {next_pair, 1'b0};
          io_rd_address2 <= {next_pair, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_io_controller.sv
// Directed scoreboard bench for fft_io_controller: bit-reversed loading, start timing,
// ordered unload with stalls, reset during compute and back-to-back frames.
module tb_fft_io_controller;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int SW = 32;

  typedef struct {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sample;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sample;
  logic          out_last;
  logic          fft_start;
  logic          fft_done;
  logic          io_wr_en;
  logic [AW-1:0] io_wr_address1;
  logic [AW-1:0] io_wr_address2;
  logic [SW-1:0] io_wr_sample1;
  logic [SW-1:0] io_wr_sample2;
  logic [AW-1:0] io_rd_address1;
  logic [AW-1:0] io_rd_address2;
  logic [SW-1:0] io_rd_sample1;
  logic [SW-1:0] io_rd_sample2;

  int            vectors;
  int            miscompares;
  int            wr_count;
  int            start_count;
  int            expected_starts;
  wr_t           wr_q[$];
  logic [SW-1:0] out_q[$];
  logic [SW-1:0] ram_mem[N];

  fft_io_controller #(
    .N(N),
    .word_size(16),
    .address_width(AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sample     (in_sample),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sample    (out_sample),
    .out_last      (out_last),
    .fft_start     (fft_start),
    .fft_done      (fft_done),
    .io_wr_en      (io_wr_en),
    .io_wr_address1(io_wr_address1),
    .io_wr_address2(io_wr_address2),
    .io_wr_sample1 (io_wr_sample1),
    .io_wr_sample2 (io_wr_sample2),
    .io_rd_address1(io_rd_address1),
    .io_rd_address2(io_rd_address2),
    .io_rd_sample1 (io_rd_sample1),
    .io_rd_sample2 (io_rd_sample2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read port model: one cycle latency, data[a] = a + 100.
  always @(posedge clk) begin
    io_rd_sample1 <= SW'(io_rd_address1) + 32'd100;
    io_rd_sample2 <= SW'(io_rd_address2) + 32'd100;
  end

  function automatic logic [AW-1:0] bitrev(input int v);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: RAM writes and output handshakes, sampled 1ns after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      if (io_wr_en) begin
        if (wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          checkOutput("wr_addr1", 64'(io_wr_address1), 64'(e.a1));
          checkOutput("wr_addr2", 64'(io_wr_address2), 64'(e.a2));
          checkOutput("wr_sample1", 64'(io_wr_sample1), 64'(e.s1));
          checkOutput("wr_sample2", 64'(io_wr_sample2), 64'(e.s2));
        end
        ram_mem[io_wr_address1] = io_wr_sample1;
        ram_mem[io_wr_address2] = io_wr_sample2;
        wr_count++;
      end
      if (fft_start) start_count++;
      if (out_valid && out_q.size() == 0) begin
        checkOutput("out_unexpected", 64'd1, 64'd0);
      end else if (out_valid && out_ready) begin
        checkOutput("out_last", 64'(out_last), 64'(out_q.size() == 1));
        checkOutput("out_sample", 64'(out_sample), 64'(out_q.pop_front()));
      end
    end
  end

  // Loads one frame of sample values base+i, with optional random gaps before each sample.
  task automatic applyStimulus(input logic [SW-1:0] base, input int max_gap);
    for (int i = 0; i < N; i++) begin
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid  = 1'b1;
      in_sample = base + SW'(i);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 64'd0, 64'd1);
      if (i % 2 == 1) wr_q.push_back('{bitrev(i - 1), bitrev(i), base + SW'(i - 1), base + SW'(i)});
      @(negedge clk);
    end
    in_valid = 1'b0;
    expected_starts++;
    checkOutput("start_t1", 64'(fft_start), 64'd0);
    checkOutput("flush_not_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("start_t2", 64'(fft_start), 64'd1);
    @(negedge clk);
    checkOutput("start_t3", 64'(fft_start), 64'd0);
  endtask

  task automatic pulseDone();
    fft_done = 1'b1;
    for (int a = 0; a < N; a++) out_q.push_back(SW'(a) + 32'd100);
    @(negedge clk);
    fft_done = 1'b0;
    checkOutput("valid_d1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("valid_d2", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("valid_d3", 64'(out_valid), 64'd1);
  endtask

  task automatic drainFrame(input bit stalls);
    int  recv;
    int  budget;
    bit  done;
    bit  s4;
    bit  s7;
    recv = 0; budget = 0; done = 1'b0; s4 = 1'b0; s7 = 1'b0;
    while (!done && budget < 400) begin
      if (out_valid && stalls && ((recv == 4 && !s4) || (recv == 7 && !s7))) begin
        if (recv == 4) s4 = 1'b1;
        else           s7 = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_valid", 64'(out_valid), 64'd1);
          checkOutput("stall_sample", 64'(out_sample), 64'(recv + 100));
        end
      end
      out_ready = 1'b1;
      if (out_valid) begin
        recv++;
        if (out_last) done = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
    checkOutput("drain_count", 64'(recv), 64'(N));
    checkOutput("ready_after_last", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; wr_count = 0; start_count = 0; expected_starts = 0;
    reset = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0; fft_done = 1'b0;
    for (int a = 0; a < N; a++) ram_mem[a] = '1;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_fft_start", 64'(fft_start), 64'd0);
    checkOutput("rst_wr_en", 64'(io_wr_en), 64'd0);
    checkOutput("rst_wr_addr", 64'({io_wr_address1, io_wr_address2}), 64'd0);
    checkOutput("rst_rd_addr", 64'({io_rd_address1, io_rd_address2}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

    $display("[TB] fft_done during LOAD is ignored");
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("ign_done_ready", 64'(in_ready), 64'd1);
      checkOutput("ign_done_valid", 64'(out_valid), 64'd0);
    end

    $display("[TB] frame 1: value = index, no gaps, output stalls");
    wr_count = 0;
    applyStimulus(32'd0, 0);
    checkOutput("f1_wr_count", 64'(wr_count), 64'd16);
    checkOutput("f1_sample1_at16", 64'(ram_mem[16]), 64'd1);
    checkOutput("f1_sample6_at12", 64'(ram_mem[12]), 64'd6);
    checkOutput("f1_sample3_at24", 64'(ram_mem[24]), 64'd3);
    repeat (4) @(negedge clk);
    pulseDone();
    drainFrame(1'b1);

    $display("[TB] frame 2: back-to-back with random input gaps");
    wr_count = 0;
    applyStimulus(32'h0002_0000, 4);
    checkOutput("f2_wr_count", 64'(wr_count), 64'd16);
    for (int i = 0; i < N; i++)
      checkOutput("f2_ram_content", 64'(ram_mem[bitrev(i)]), 64'(32'h0002_0000 + 32'(i)));
    pulseDone();
    drainFrame(1'b0);

    $display("[TB] frame 3: reset during COMPUTE, then frame 4 reload");
    applyStimulus(32'h0003_0000, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_start", 64'(fft_start), 64'd0);
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("post_rst_ready", 64'(in_ready), 64'd1);
    end
    applyStimulus(32'h0004_0000, 2);
    pulseDone();
    drainFrame(1'b0);

    repeat (3) @(negedge clk);
    checkOutput("start_count", 64'(start_count), 64'(expected_starts));
    checkOutput("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    checkOutput("out_queue_empty", 64'(out_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
